// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save multi-operand accumulator:
// FSM state encoding and the accumulator-width derivation.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Guard bits make sums of up to 2**guard operands exact.
  function automatic int aw_of(input int width, input int guard);
    return width + guard;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 compressor: a + b + c == sum + carry (mod 2**W), carry pre-shifted.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  // The majority out of bit W-1 would land at weight 2**W, outside the modulus.
  assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_acc_seq.sv
// Packet accumulator: running total kept as sum/carry vectors, resolved by a
// single carry-propagate add after the last beat, then held until consumed.
module csa_acc_seq
  import csa_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int GUARD = 4,
  parameter  int CNT_W = 8,
  localparam int AW    = aw_of(WIDTH, GUARD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  localparam int MAX_OPS = 1 << GUARD;

  state_e           state, state_nxt;
  logic [AW-1:0]    acc_s, acc_c;
  logic [AW-1:0]    csa_sum, csa_carry;
  logic [AW-1:0]    in_ext;
  logic [CNT_W-1:0] count, count_inc;
  logic             ovf, ovf_hit, accept;

  assign in_ext    = AW'(in_data);
  assign accept    = in_valid & in_ready;
  assign count_inc = (count == '1) ? count : count + 1'b1;
  // The incoming beat is number count+1; it overflows once count reaches MAX_OPS.
  assign ovf_hit   = int'(count) >= MAX_OPS;
  assign busy      = (state != IDLE);

  csa_3to2 #(.W(AW)) u_csa (
    .a     (acc_s),
    .b     (acc_c),
    .c     (in_ext),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, otherwise any path
  // that skips an assignment infers a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? RESOLVE : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = RESOLVE;
      end
      RESOLVE: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath is a handful of registers, not a memory, so all of it is
  // reset; a reset mid-packet must also clear the previous result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_s     <= '0;
      acc_c     <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          acc_s <= in_ext;
          acc_c <= '0;
          count <= CNT_W'(1);
          ovf   <= 1'b0;
        end
        ACC: if (accept) begin
          acc_s <= csa_sum;
          acc_c <= csa_carry;
          count <= count_inc;
          if (ovf_hit) ovf <= 1'b1;
        end
        RESOLVE: begin
          out_sum   <= acc_s + acc_c;
          out_count <= count;
          out_ovf   <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_acc_seq.sv
// Directed and randomized checks of csa_acc_seq at WIDTH=8, GUARD=2 (AW=10).
module tb_csa_acc_seq;

  localparam int WIDTH = 8;
  localparam int GUARD = 2;
  localparam int CNT_W = 8;
  localparam int AW    = WIDTH + GUARD;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  csa_acc_seq #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat from a negedge and return 1ns after the edge that takes it.
  task automatic put(input logic [WIDTH-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("beat_accepted", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for out_valid, check the result, complete the handshake.
  task automatic take(input string tag, input logic [AW-1:0] s,
                      input logic [CNT_W-1:0] c, input logic o);
    int t = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(s));
    check({tag, "_count"}, 32'(out_count), 32'(c));
    check({tag, "_ovf"},   32'(out_ovf),   32'(o));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0]    ref_sum;
    logic [CNT_W-1:0] ref_cnt;
    logic [AW-1:0]    held_sum;
    logic [WIDTH-1:0] d;
    int               n_ops, t;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three 0xFF beats: 765 = 0x2FD; result valid one edge after last accept.
    put(8'hFF, 1'b0);
    put(8'hFF, 1'b0);
    put(8'hFF, 1'b1);
    check("lat_resolve_valid", 32'(out_valid), 32'd0);
    check("lat_resolve_ready", 32'(in_ready),  32'd0);
    check("lat_resolve_busy",  32'(busy),      32'd1);
    @(posedge clk);
    #1;
    check("lat_done_valid", 32'(out_valid), 32'd1);
    check("p1_sum",   32'(out_sum),   32'h2FD);
    check("p1_count", 32'(out_count), 32'd3);
    check("p1_ovf",   32'(out_ovf),   32'd0);
    @(posedge clk);
    #1;
    check("p1_idle_busy", 32'(busy), 32'd0);

    // Single beat: accept, RESOLVE, DONE handshake -> IDLE after 3 edges.
    put(8'h5A, 1'b1);
    @(posedge clk);
    #1;
    check("p2_valid", 32'(out_valid), 32'd1);
    check("p2_sum",   32'(out_sum),   32'h05A);
    check("p2_count", 32'(out_count), 32'd1);
    @(posedge clk);
    #1;
    check("p2_idle_busy",  32'(busy),     32'd0);
    check("p2_idle_ready", 32'(in_ready), 32'd1);

    // Five 0xFF beats exceed 2**GUARD: 1275 mod 1024 = 0x0FB, overflow flagged.
    for (int i = 0; i < 5; i++) put(8'hFF, (i == 4));
    take("p3", 10'h0FB, 8'd5, 1'b1);
    put(8'h07, 1'b1);
    take("p4", 10'h007, 8'd1, 1'b0);

    // Gapped beats with a stalled consumer; beats offered during DONE are ignored.
    out_ready = 1'b0;
    put(8'h01, 1'b0);
    repeat (2) @(negedge clk);
    put(8'h02, 1'b0);
    repeat (2) @(negedge clk);
    put(8'h03, 1'b1);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("p5_valid", 32'(out_valid), 32'd1);
    check("p5_sum",   32'(out_sum),   32'h006);
    check("p5_count", 32'(out_count), 32'd3);
    held_sum = out_sum;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sum",   32'(out_sum),   32'(held_sum));
      check("stall_count", 32'(out_count), 32'd3);
      check("stall_ready", 32'(in_ready),  32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("p5_idle_busy",  32'(busy),      32'd0);
    check("p5_idle_ready", 32'(in_ready),  32'd1);
    check("p5_idle_valid", 32'(out_valid), 32'd0);

    // Reset mid-packet clears everything at once, then a fresh packet works.
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",   32'(out_sum),   32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_ovf",   32'(out_ovf),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    put(8'h10, 1'b0);
    put(8'h20, 1'b1);
    take("p6", 10'h030, 8'd2, 1'b0);

    // Random packets of 1..4 operands with random gaps and consumer stalls.
    for (int p = 0; p < 25; p++) begin
      n_ops   = $urandom_range(1, 4);
      ref_sum = '0;
      ref_cnt = '0;
      for (int i = 0; i < n_ops; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        d = WIDTH'($urandom);
        ref_sum = ref_sum + AW'(d);
        ref_cnt = ref_cnt + 1'b1;
        put(d, (i == n_ops - 1));
      end
      t = 0;
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      while (!(out_valid && out_ready) && t < 100) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        t++;
      end
      check("rnd_handshake", 32'(out_valid & out_ready), 32'd1);
      check("rnd_sum",       32'(out_sum),   32'(ref_sum));
      check("rnd_count",     32'(out_count), 32'(ref_cnt));
      check("rnd_ovf",       32'(out_ovf),   32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      check("rnd_idle", 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
